// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding word memory responder with wait states
// Request/response valid-ready slave over an internal word array; out-of-range addresses report an error.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_sync,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              access;
  logic              acc_write;
  logic              acc_in_range;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] rd_word;

  // With no wait states the access uses the live request in the acceptance cycle.
  always_comb begin
    accept       = (state == IDLE) && req_valid;
    access       = (WAIT_STATES == 0) ? accept : ((state == WAIT) && (wait_cnt == 4'd1));
    acc_write    = (state == IDLE) ? req_write : lat_write;
    acc_addr     = (state == IDLE) ? req_addr  : lat_addr;
    acc_wdata    = (state == IDLE) ? req_wdata : lat_wdata;
    acc_in_range = ({1'b0, acc_addr} < DEPTH_LIM);
    acc_idx      = acc_addr[IDX_W-1:0];
    rd_word      = mem[acc_idx];
  end

  // Array is never cleared; a reset in the access cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst_sync && access && acc_write && acc_in_range) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase

      if (access) begin
        resp_err   <= !acc_in_range;
        resp_rdata <= (acc_in_range && !acc_write) ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - bench for mem_responder at WAIT_STATES 2, 0 and 3
// Directed protocol steps plus randomized traffic checked against an address-map model.
module tb_mem_responder;

  localparam int N     = 3;
  localparam int DEPTH = 200;

  logic        clk = 1'b0;
  logic        rst_sync   [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_write  [N];
  logic [7:0]  req_addr   [N];
  logic [15:0] req_wdata  [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [15:0] resp_rdata [N];
  logic        resp_err   [N];

  int ws_tab [N] = '{2, 0, 3};
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] ref_mem [int];
  int wlist [N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH),
      .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk(clk), .rst_sync(rst_sync[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g])
    );
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory is a map from address to last written word; anything at or beyond DEPTH errors.
  task automatic model(input int k, input bit wr, input logic [7:0] a, input logic [15:0] wd,
                       output logic [15:0] rd, output logic er);
    int key = k * 256 + int'(a);
    if (int'(a) >= DEPTH) begin
      rd = 16'h0; er = 1'b1;
    end else if (wr) begin
      ref_mem[key] = wd; rd = 16'h0; er = 1'b0;
      wlist[k].push_back(int'(a));
    end else begin
      rd = ref_mem.exists(key) ? ref_mem[key] : 16'h0; er = 1'b0;
    end
  endtask

  // Called at a falling edge; returns once the response is visible.
  task automatic issue(input int k, input bit wr, input logic [7:0] a, input logic [15:0] wd,
                       input bit keep_valid);
    int n;
    int t;
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = wd;
    n = 0;
    while (!req_ready[k] && n < 40) begin @(negedge clk); n++; end
    check("req_ready_at_accept", 32'(req_ready[k]), 1);
    t = cyc;
    @(negedge clk);
    req_valid[k] = keep_valid;
    req_write[k] = 1'($urandom); req_addr[k] = 8'($urandom); req_wdata[k] = 16'($urandom);
    n = 0;
    while (!resp_valid[k] && n < 40) begin @(negedge clk); n++; end
    check("resp_valid_seen", 32'(resp_valid[k]), 1);
    check("latency", 32'(cyc - t), 32'(1 + ws_tab[k]));
  endtask

  task automatic finish_resp(input int k, input int hold, input logic [15:0] erd, input logic erre);
    check("rdata", 32'(resp_rdata[k]), 32'(erd));
    check("err", 32'(resp_err[k]), 32'(erre));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[k]), 1);
      check("hold_rdata", 32'(resp_rdata[k]), 32'(erd));
      check("hold_req_ready", 32'(req_ready[k]), 0);
    end
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    req_valid[k]  = 1'b0;
    check("req_ready_after_hs", 32'(req_ready[k]), 1);
    check("resp_valid_after_hs", 32'(resp_valid[k]), 0);
  endtask

  task automatic txn(input int k, input bit wr, input logic [7:0] a, input logic [15:0] wd,
                     input int hold, input bit keep_valid);
    logic [15:0] erd;
    logic        erre;
    model(k, wr, a, wd, erd, erre);
    issue(k, wr, a, wd, keep_valid);
    finish_resp(k, hold, erd, erre);
  endtask

  initial begin
    logic [15:0] erd;
    logic        erre;
    for (int k = 0; k < N; k++) begin
      rst_sync[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = 8'h0; req_wdata[k] = 16'h0; resp_ready[k] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("reset_req_ready", 32'(req_ready[k]), 1);
      check("reset_resp_valid", 32'(resp_valid[k]), 0);
      check("reset_rdata", 32'(resp_rdata[k]), 0);
      check("reset_err", 32'(resp_err[k]), 0);
      rst_sync[k] = 1'b0;
    end
    @(negedge clk);

    // Write then read with backpressure (WAIT_STATES=2)
    txn(0, 1'b1, 8'h05, 16'h1234, 0, 1'b0);
    txn(0, 1'b0, 8'h05, 16'h0000, 5, 1'b1);
    check("rd_0x05_value", 32'(ref_mem[5]), 32'h1234);

    // Out of range with DEPTH=200
    txn(0, 1'b1, 8'h00, 16'h0001, 0, 1'b0);
    txn(0, 1'b1, 8'hC8, 16'hBEEF, 0, 1'b0);
    txn(0, 1'b0, 8'hC8, 16'h0000, 1, 1'b0);
    txn(0, 1'b0, 8'h00, 16'h0000, 0, 1'b0);

    // Back-to-back reads with no wait states
    for (int a = 0; a < 4; a++) txn(1, 1'b1, 8'(a), 16'($urandom), 0, 1'b0);
    req_valid[1] = 1'b1; resp_ready[1] = 1'b1; req_write[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr[1] = 8'(i / 2);
      check("tp_req_ready", 32'(req_ready[1]), 32'(i % 2 == 0));
      check("tp_resp_valid", 32'(resp_valid[1]), 32'(i % 2 == 1));
      if (i % 2 == 1) check("tp_rdata", 32'(resp_rdata[1]), 32'(ref_mem[256 + (i - 1) / 2]));
      @(negedge clk);
    end
    req_valid[1] = 1'b0; resp_ready[1] = 1'b0;
    check("tp_end_req_ready", 32'(req_ready[1]), 1);
    check("tp_end_resp_valid", 32'(resp_valid[1]), 0);
    @(negedge clk);

    // Reset aborts a pending write (WAIT_STATES=3)
    txn(2, 1'b1, 8'h07, 16'h00AA, 0, 1'b0);
    check("abort_ready_c0", 32'(req_ready[2]), 1);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 8'h07; req_wdata[2] = 16'h5555;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst_sync[2] = 1'b1;
    @(negedge clk);
    rst_sync[2] = 1'b0;
    check("abort_req_ready_c3", 32'(req_ready[2]), 1);
    check("abort_resp_valid_c3", 32'(resp_valid[2]), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid[2]), 0);
    end
    txn(2, 1'b0, 8'h07, 16'h0000, 0, 1'b0);

    // Reset while a response is pending
    txn(0, 1'b1, 8'h10, 16'h0033, 0, 1'b0);
    issue(0, 1'b0, 8'h10, 16'h0000, 1'b0);
    check("rresp_rdata_before", 32'(resp_rdata[0]), 32'h0033);
    rst_sync[0] = 1'b1;
    @(negedge clk);
    rst_sync[0] = 1'b0;
    check("rresp_valid", 32'(resp_valid[0]), 0);
    check("rresp_rdata", 32'(resp_rdata[0]), 0);
    check("rresp_err", 32'(resp_err[0]), 0);
    check("rresp_req_ready", 32'(req_ready[0]), 1);
    issue(0, 1'b0, 8'hC9, 16'h0000, 1'b0);
    check("rresp_err_before", 32'(resp_err[0]), 1);
    rst_sync[0] = 1'b1;
    @(negedge clk);
    rst_sync[0] = 1'b0;
    check("rresp_err_cleared", 32'(resp_err[0]), 0);
    check("rresp_valid_2", 32'(resp_valid[0]), 0);

    // Randomized traffic on every instance
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 25; i++) begin
        int r;
        bit wr;
        logic [7:0] a;
        r = int'($urandom_range(0, 9));
        if (r < 4 || wlist[k].size() == 0) begin
          wr = 1'b1; a = 8'($urandom_range(0, DEPTH - 1));
        end else if (r < 5) begin
          wr = 1'($urandom); a = 8'($urandom_range(DEPTH, 255));
        end else begin
          wr = 1'b0; a = 8'(wlist[k][$urandom_range(0, wlist[k].size() - 1)]);
        end
        txn(k, wr, a, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end
    end

    model(0, 1'b0, 8'h05, 16'h0, erd, erre);
    issue(0, 1'b0, 8'h05, 16'h0, 1'b0);
    finish_resp(0, 0, erd, erre);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
